trng_sample_ctrl: RTL and testbench

Sequencer for the on-chip ring-oscillator entropy source. It enables the oscillator and waits a warm-up period, then samples the raw bit through a synchronizer at a fixed divided rate and runs a repetition-count health test. It assembles accepted bits into bytes and hands each byte out over a valid/ready handshake. It sits between the ring-oscillator instance and the top-level output pins.

---
 rtl/trng_sample_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_trng_sample_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_sample_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trng_sample_ctrl                                              |
// | Purpose  : Ring-oscillator entropy sequencer. Enables the oscillator,    |
// |            waits a warm-up period, then samples the synchronized raw bit |
// |            at a divided rate. Each sample goes through a repetition-count|
// |            health test. Accepted bits are packed MSB-first into a byte,  |
// |            and the byte is offered on a valid/ready handshake.           |
// | Ports    : clk, rst_n (async, active-low), start (level request),        |
// |            osc_bit (async raw bit), osc_en, rnd_byte/rnd_valid/rnd_ready,|
// |            busy, health_fail.                                            |
// | Options  : TRNG_VN_DEBIAS_EN -- von Neumann pair debiasing of samples.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module trng_sample_ctrl #(
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 8,
    parameter int REP_LIMIT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       osc_bit,
    output logic       osc_en,
    output logic [7:0] rnd_byte,
    output logic       rnd_valid,
    input  logic       rnd_ready,
    output logic       busy,
    output logic       health_fail
);

    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W  = $clog2(REP_LIMIT + 1);

    localparam logic [WARM_W-1:0] c_WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  c_DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0]  c_REP_LIMIT = RUN_W'(REP_LIMIT);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WARMUP = 3'd1;
    localparam logic [2:0] c_SAMPLE = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd3;
    localparam logic [2:0] c_FAIL   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              prev_q, prev_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        byte_q, byte_d;
    logic              osc_en_q, osc_en_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic              busy_q, busy_d;
    logic              health_fail_q, health_fail_d;
`ifdef TRNG_VN_DEBIAS_EN
    logic              pair_q, pair_d;     // 1: first half of a pair is held
    logic              first_q, first_d;
`endif

    logic              clr;
    logic              strobe;
    logic              sample;
    logic              accept;
    logic              acc_bit;
    logic [RUN_W-1:0]  run_next;

    // ---------------- state / data registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= c_IDLE;
            sync_q        <= 2'b00;
            warm_cnt_q    <= '0;
            div_cnt_q     <= '0;
            run_cnt_q     <= '0;
            prev_q        <= 1'b0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            byte_q        <= 8'h00;
            osc_en_q      <= 1'b0;
            rnd_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            health_fail_q <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_q        <= 1'b0;
            first_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            warm_cnt_q    <= warm_cnt_d;
            div_cnt_q     <= div_cnt_d;
            run_cnt_q     <= run_cnt_d;
            prev_q        <= prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            byte_q        <= byte_d;
            osc_en_q      <= osc_en_d;
            rnd_valid_q   <= rnd_valid_d;
            busy_q        <= busy_d;
            health_fail_q <= health_fail_d;
`ifdef TRNG_VN_DEBIAS_EN
            pair_q        <= pair_d;
            first_q       <= first_d;
`endif
        end
    end

    // ---------------- next-state and datapath ----------------
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], osc_bit};
        warm_cnt_d = warm_cnt_q;
        div_cnt_d  = div_cnt_q;
        run_cnt_d  = run_cnt_q;
        prev_d     = prev_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        clr        = 1'b0;
        strobe     = 1'b0;
        sample     = sync_q[1];
        accept     = 1'b0;
        acc_bit    = 1'b0;
        run_next   = '0;
`ifdef TRNG_VN_DEBIAS_EN
        pair_d     = pair_q;
        first_d    = first_q;
`endif
        case (state_q)
            c_IDLE: begin
                clr = 1'b1;
                if (start) begin
                    state_d = c_WARMUP;
                end
            end
            c_WARMUP: begin
                if (!start) begin
                    state_d = c_IDLE;
                    clr     = 1'b1;
                end else if (warm_cnt_q == c_WARM_LAST) begin
                    state_d = c_SAMPLE;
                    clr     = 1'b1;   // divider, run counter and pair phase start fresh
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            c_SAMPLE: begin
                if (!start) begin
                    // Abort takes priority over a coincident strobe.
                    state_d = c_IDLE;
                    clr     = 1'b1;
                end else begin
                    if (div_cnt_q == c_DIV_LAST) begin
                        div_cnt_d = '0;
                        strobe    = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                    if (strobe) begin
                        // A zero run count marks the first sample after entry.
                        run_next  = ((run_cnt_q != '0) && (sample == prev_q)) ?
                                    run_cnt_q + 1'b1 : RUN_W'(1);
                        run_cnt_d = run_next;
                        prev_d    = sample;
                        if (run_next == c_REP_LIMIT) begin
                            // The failing bit is dropped, so no byte can finish here.
                            state_d = c_FAIL;
                        end else begin
`ifdef TRNG_VN_DEBIAS_EN
                            if (!pair_q) begin
                                pair_d  = 1'b1;
                                first_d = sample;
                            end else begin
                                pair_d  = 1'b0;
                                accept  = (first_q != sample);
                                acc_bit = first_q;
                            end
`else
                            accept  = 1'b1;
                            acc_bit = sample;
`endif
                        end
                    end
                    if (accept) begin
                        shift_d = {shift_q[6:0], acc_bit};
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = c_DONE;
                            byte_d    = {shift_q[6:0], acc_bit};
                            bit_cnt_d = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
            c_DONE: begin
                if (rnd_valid_q && rnd_ready) begin
                    state_d = c_IDLE;
                end
            end
            c_FAIL: begin
                if (!start) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (clr) begin
            warm_cnt_d = '0;
            div_cnt_d  = '0;
            run_cnt_d  = '0;
            bit_cnt_d  = 3'd0;
            shift_d    = 8'h00;
`ifdef TRNG_VN_DEBIAS_EN
            pair_d     = 1'b0;
`endif
        end
    end

    // ---------------- registered outputs, decoded from next state ----------------
    always_comb begin
        osc_en_d      = (state_d == c_WARMUP) || (state_d == c_SAMPLE);
        rnd_valid_d   = (state_d == c_DONE);
        busy_d        = (state_d != c_IDLE);
        health_fail_d = (state_d == c_FAIL);
    end

    assign osc_en      = osc_en_q;
    assign rnd_byte    = byte_q;
    assign rnd_valid   = rnd_valid_q;
    assign busy        = busy_q;
    assign health_fail = health_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_sample_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_trng_sample_ctrl                                           |
// | Purpose  : Self-checking bench for trng_sample_ctrl. Sample sequences    |
// |            are scored by a list-level model of the health test, the      |
// |            optional pair debiasing (TRNG_VN_DEBIAS_EN), and byte packing.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_trng_sample_ctrl;

    localparam int W = 4;
    localparam int D = 2;
    localparam int R = 4;
`ifdef TRNG_VN_DEBIAS_EN
    localparam bit DEBIAS = 1'b1;
`else
    localparam bit DEBIAS = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       osc_bit   = 1'b0;
    logic       rnd_ready = 1'b0;
    logic       osc_en;
    logic [7:0] rnd_byte;
    logic       rnd_valid;
    logic       busy;
    logic       health_fail;

    int checks = 0;
    int errors = 0;

    bit smp [0:127];
    int nsmp = 0;

    trng_sample_ctrl #(
        .WARMUP_CYCLES (W),
        .SAMPLE_DIV    (D),
        .REP_LIMIT     (R)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .osc_bit     (osc_bit),
        .osc_en      (osc_en),
        .rnd_byte    (rnd_byte),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .busy        (busy),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    // Walk the raw sample list: which strobe ends the run, and how.
    function automatic void model(output int ev_strobe, output bit ev_fail,
                                  output logic [7:0] byte_o);
        int run   = 0;
        bit prev  = 1'b0;
        int nacc  = 0;
        int acc   = 0;
        bit have_a = 1'b0;
        bit a     = 1'b0;
        bit take;
        bit b;
        ev_strobe = 0;
        ev_fail   = 1'b0;
        byte_o    = 8'h00;
        for (int k = 0; k < nsmp; k++) begin
            run  = (k > 0 && smp[k] == prev) ? run + 1 : 1;
            prev = smp[k];
            if (run >= R) begin
                ev_strobe = k + 1;
                ev_fail   = 1'b1;
                return;
            end
            take = 1'b0;
            b    = smp[k];
            if (DEBIAS) begin
                if (!have_a) begin
                    have_a = 1'b1;
                    a      = smp[k];
                end else begin
                    have_a = 1'b0;
                    take   = (a != smp[k]);
                    b      = a;
                end
            end else begin
                take = 1'b1;
            end
            if (take) begin
                acc  = (acc * 2 + int'(b)) % 256;
                nacc = nacc + 1;
                if (nacc == 8) begin
                    ev_strobe = k + 1;
                    byte_o    = acc[7:0];
                    return;
                end
            end
        end
    endfunction

    // Raw samples that make the block accept exactly the bits of v.
    task automatic load_bits(input logic [7:0] v);
        nsmp = 0;
        for (int i = 7; i >= 0; i--) begin
            smp[nsmp] = v[i];
            nsmp++;
            if (DEBIAS) begin
                smp[nsmp] = !v[i];
                nsmp++;
            end
        end
    endtask

    // rst_e = -2 means reset right when the run's terminal state is reached.
    task automatic run_case(input string name, input int hold, input bit keep_start,
                            input int abort_e, input int rst_e);
        int         ev_strobe;
        bit         ev_fail;
        logic [7:0] exp_byte;
        int         end_e;
        int         tgt;
        logic [3:0] got;
        model(ev_strobe, ev_fail, exp_byte);
        end_e = (ev_strobe == 0) ? 100000 : W + ev_strobe * D;
        @(negedge clk);
        start     = 1'b1;
        rnd_ready = (hold == 0);
        osc_bit   = 1'b0;
        @(posedge clk);                       // E0
        for (int e = 0; e <= 400; e++) begin
            @(negedge clk);
            // Value present at edge e+1 is the one seen by the strobe at edge e+3.
            tgt = e + 3 - W;
            if (tgt > 0 && (tgt % D) == 0 && (tgt / D) <= nsmp) osc_bit = smp[tgt / D - 1];
            got = {osc_en, busy, rnd_valid, health_fail};
            checks++;
            if (e < end_e) begin
                if (got !== 4'b1100) begin
                    errors++;
                    $display("FAIL %s active e=%0d flags got %b want 1100", name, e, got);
                end
            end else if (ev_fail) begin
                if (got !== 4'b0101) begin
                    errors++;
                    $display("FAIL %s health e=%0d flags got %b want 0101", name, e, got);
                end
            end else begin
                if (got !== 4'b0110 || rnd_byte !== exp_byte) begin
                    errors++;
                    $display("FAIL %s done e=%0d flags got %b want 0110 byte got %h want %h",
                             name, e, got, rnd_byte, exp_byte);
                end
            end
            if (rst_e == e || (rst_e == -2 && e == end_e)) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({osc_en, busy, rnd_valid, health_fail, rnd_byte} !== 12'h000) begin
                    errors++;
                    $display("FAIL %s async_reset got %b/%h want 0000/00", name,
                             {osc_en, busy, rnd_valid, health_fail}, rnd_byte);
                end
                @(negedge clk);
                start     = 1'b0;
                rnd_ready = 1'b0;
                rst_n     = 1'b1;
                return;
            end
            if (e == abort_e) begin
                start = 1'b0;
                @(negedge clk);
                checks++;
                if ({osc_en, busy, rnd_valid, health_fail} !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s abort got %b want 0000", name,
                             {osc_en, busy, rnd_valid, health_fail});
                end
                return;
            end
            if (e == end_e) begin
                if (ev_fail) begin
                    repeat (3) begin
                        @(negedge clk);
                        checks++;
                        if ({osc_en, busy, rnd_valid, health_fail} !== 4'b0101) begin
                            errors++;
                            $display("FAIL %s fail_sticky got %b want 0101", name,
                                     {osc_en, busy, rnd_valid, health_fail});
                        end
                    end
                    start = 1'b0;
                    @(negedge clk);
                    checks++;
                    if ({osc_en, busy, rnd_valid, health_fail} !== 4'b0000) begin
                        errors++;
                        $display("FAIL %s fail_exit got %b want 0000", name,
                                 {osc_en, busy, rnd_valid, health_fail});
                    end
                end else begin
                    if (!keep_start) start = 1'b0;   // ignored while a byte is pending
                    for (int h = 0; h < hold; h++) begin
                        @(negedge clk);
                        checks++;
                        if ({osc_en, busy, rnd_valid, health_fail} !== 4'b0110 ||
                            rnd_byte !== exp_byte) begin
                            errors++;
                            $display("FAIL %s hold h=%0d got %b byte %h want 0110 byte %h",
                                     name, h, {osc_en, busy, rnd_valid, health_fail},
                                     rnd_byte, exp_byte);
                        end
                    end
                    rnd_ready = 1'b1;
                    @(negedge clk);
                    checks++;
                    if ({osc_en, busy, rnd_valid, health_fail} !== 4'b0000 ||
                        rnd_byte !== exp_byte) begin
                        errors++;
                        $display("FAIL %s transfer got %b byte %h want 0000 byte %h", name,
                                 {osc_en, busy, rnd_valid, health_fail}, rnd_byte, exp_byte);
                    end
                    @(negedge clk);
                    checks++;
                    if ({osc_en, busy} !== {keep_start, keep_start}) begin
                        errors++;
                        $display("FAIL %s rearm got osc_en/busy %b want %b", name,
                                 {osc_en, busy}, {keep_start, keep_start});
                    end
                    start     = 1'b0;
                    rnd_ready = 1'b0;
                    @(negedge clk);
                    checks++;
                    if ({osc_en, busy, rnd_valid, health_fail} !== 4'b0000) begin
                        errors++;
                        $display("FAIL %s idle got %b want 0000", name,
                                 {osc_en, busy, rnd_valid, health_fail});
                    end
                end
                return;
            end
        end
        errors++;
        $display("FAIL %s timeout no terminal event got %b want event", name,
                 {osc_en, busy, rnd_valid, health_fail});
        start     = 1'b0;
        rnd_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({osc_en, busy, rnd_valid, health_fail, rnd_byte} !== 12'h000) begin
            errors++;
            $display("FAIL reset got %b/%h want 0000/00",
                     {osc_en, busy, rnd_valid, health_fail}, rnd_byte);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known_byte();
        if (DEBIAS) begin
            bit pairs [0:19] = '{1,0, 1,1, 0,1, 0,0, 1,0, 1,0, 0,1, 0,1, 0,1, 1,0};
            for (int i = 0; i < 20; i++) smp[i] = pairs[i];
            nsmp = 20;
        end else begin
            load_bits(8'hB2);
        end
        run_case("known_byte", 0, 1'b0, -1, -1);
    endtask

    task automatic test_stuck();
        for (int i = 0; i < 16; i++) smp[i] = 1'b1;
        nsmp = 16;
        run_case("stuck_one", 0, 1'b1, -1, -1);
    endtask

    task automatic test_backpressure();
        load_bits(8'h96);
        run_case("backpressure", 20, 1'b1, -1, -1);
    endtask

    task automatic test_abort();
        bit pre [0:7] = '{1, 1, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) smp[i] = pre[i];
        nsmp = 8;
        run_case("abort_3_strobes", 0, 1'b1, W + 3 * D, -1);
        load_bits(8'h55);
        run_case("restart_55", 0, 1'b0, -1, -1);
    endtask

    task automatic test_abort_collision();
        load_bits(8'hA5);
        run_case("abort_on_last_strobe", 0, 1'b1, W + (DEBIAS ? 16 : 8) * D - 1, -1);
    endtask

    task automatic test_fail_on_last();
        bit s [0:7] = '{1, 0, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) smp[i] = s[i];
        nsmp = 8;
        run_case("fail_on_last", 0, 1'b1, -1, -1);
    endtask

    task automatic test_async_reset();
        load_bits(8'h69);
        run_case("reset_in_sample", 0, 1'b1, -1, W + 2 * D + 1);
        load_bits(8'h69);
        run_case("reset_in_done", 30, 1'b1, -1, -2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 128; i++) smp[i] = 1'($urandom_range(0, 1));
            nsmp = 128;
            run_case("random", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_known_byte();
        test_stuck();
        test_backpressure();
        test_abort();
        test_abort_collision();
        test_fail_on_last();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
